// File: rtl/i2s_slave_transceiver_pkg.sv
// i2s_slave_transceiver_pkg: shared types and constants for the slave I2S port.
// Channel encoding follows LRCK polarity (high = left).
package i2s_slave_transceiver_pkg;

    typedef enum logic {
        CH_RIGHT = 1'b0,
        CH_LEFT  = 1'b1
    } ch_e;

    localparam int DATA_WIDTH_DEF = 16;

    localparam bit I2S_MODE_STD = 1'b1;
    localparam bit I2S_MODE_LJ  = 1'b0;

endpackage

// File: rtl/i2s_slave_transceiver_sync_edge_det.sv
// i2s_slave_transceiver_sync_edge_det: multi-flop synchronizer for one async pin.
// A history flop behind the last stage yields single-cycle rise/fall pulses.
module i2s_slave_transceiver_sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iD,
    output logic oSYNC,
    output logic oRISE,
    output logic oFALL
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // shift the pin into the chain; history trails the last stage by one cycle
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], iD};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // chain and history registers, cleared by reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign oSYNC = sync_q[SYNC_STAGES-1];
    assign oRISE = oSYNC & ~hist_q;
    assign oFALL = ~oSYNC & hist_q;

endmodule

// File: rtl/i2s_slave_transceiver.sv
// i2s_slave_transceiver: slave-mode I2S port with externally driven BCK/LRCK.
// Pins are oversampled on iCLK; RX acts on BCK rises, TX on BCK falls.
module i2s_slave_transceiver
    import i2s_slave_transceiver_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter bit I2S_MODE    = I2S_MODE_STD,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iAUD_BCK,
    input  logic                         iAUD_LRCK,
    input  logic                         iAUD_ADCDAT,
    output logic                         oAUD_DATA,
    input  logic signed [DATA_WIDTH-1:0] iAUD_extL,
    input  logic signed [DATA_WIDTH-1:0] iAUD_extR,
    output logic signed [DATA_WIDTH-1:0] oAUD_inL,
    output logic signed [DATA_WIDTH-1:0] oAUD_inR,
    output logic                         oSAMPLE_VALID,
    output logic                         oDAC_LOAD,
    output logic                         oFRAME_ERR
);

    localparam int            CW   = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic bck_sync, bck_rise, bck_fall;
    logic lrck_s, lrck_rise, lrck_fall;
    logic adc_s, adc_rise, adc_fall;
    logic unused_sync;

    i2s_slave_transceiver_sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bck (
        .iCLK (iCLK),
        .iRST (iRST),
        .iD   (iAUD_BCK),
        .oSYNC(bck_sync),
        .oRISE(bck_rise),
        .oFALL(bck_fall)
    );

    i2s_slave_transceiver_sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lrck (
        .iCLK (iCLK),
        .iRST (iRST),
        .iD   (iAUD_LRCK),
        .oSYNC(lrck_s),
        .oRISE(lrck_rise),
        .oFALL(lrck_fall)
    );

    i2s_slave_transceiver_sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_adc (
        .iCLK (iCLK),
        .iRST (iRST),
        .iD   (iAUD_ADCDAT),
        .oSYNC(adc_s),
        .oRISE(adc_rise),
        .oFALL(adc_fall)
    );

    assign unused_sync = ^{bck_sync, lrck_rise, lrck_fall, adc_rise, adc_fall};

    // RX state
    logic                  rx_primed_q, rx_primed_d;
    logic                  rx_armed_q, rx_armed_d;
    logic                  rx_lr_q, rx_lr_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic                  left_ok_q, left_ok_d;
    logic [DATA_WIDTH-1:0] in_l_q, in_l_d;
    logic [DATA_WIDTH-1:0] in_r_q, in_r_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    // TX state
    logic                  tx_primed_q, tx_primed_d;
    logic                  tx_lr_q, tx_lr_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] tx_hold_r_q, tx_hold_r_d;
    logic                  dout_q, dout_d;
    logic                  load_q, load_d;
    logic [DATA_WIDTH-1:0] tx_word;

    // RX: first rise after reset only records LRCK, the first channel start arms capture
    always_comb begin
        rx_primed_d = rx_primed_q;
        rx_armed_d  = rx_armed_q;
        rx_lr_d     = rx_lr_q;
        rx_cnt_d    = rx_cnt_q;
        rx_sr_d     = rx_sr_q;
        hold_l_d    = hold_l_q;
        left_ok_d   = left_ok_q;
        in_l_d      = in_l_q;
        in_r_d      = in_r_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        if (bck_rise) begin
            rx_primed_d = 1'b1;
            rx_lr_d     = lrck_s;
            if (rx_primed_q && (lrck_s != rx_lr_q)) begin
                rx_armed_d = 1'b1;
                if (rx_armed_q) begin
                    if (rx_cnt_q == FULL) begin
                        if (rx_lr_q == CH_LEFT) begin
                            hold_l_d  = rx_sr_q;
                            left_ok_d = 1'b1;
                        end else begin
                            left_ok_d = 1'b0;
                            if (left_ok_q) begin
                                in_l_d  = hold_l_q;
                                in_r_d  = rx_sr_q;
                                valid_d = 1'b1;
                            end
                        end
                    end else begin
                        ferr_d    = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
                if (I2S_MODE == I2S_MODE_STD) begin
                    rx_cnt_d = '0;
                end else begin
                    rx_cnt_d = ONE;
                    rx_sr_d  = {rx_sr_q[DATA_WIDTH-2:0], adc_s};
                end
            end else if (rx_armed_q && (rx_cnt_q != FULL)) begin
                rx_cnt_d = rx_cnt_q + ONE;
                rx_sr_d  = {rx_sr_q[DATA_WIDTH-2:0], adc_s};
            end
        end
    end

    // TX: channel start reloads the shifter, otherwise shift MSB first then idle low
    always_comb begin
        tx_primed_d = tx_primed_q;
        tx_lr_d     = tx_lr_q;
        tx_cnt_d    = tx_cnt_q;
        tx_sr_d     = tx_sr_q;
        tx_hold_r_d = tx_hold_r_q;
        dout_d      = dout_q;
        load_d      = 1'b0;
        tx_word     = tx_hold_r_q;
        if (bck_fall) begin
            tx_primed_d = 1'b1;
            tx_lr_d     = lrck_s;
            if (tx_primed_q && (lrck_s != tx_lr_q)) begin
                if (lrck_s == CH_LEFT) begin
                    tx_hold_r_d = iAUD_extR;
                    load_d      = 1'b1;
                    tx_word     = iAUD_extL;
                end
                if (I2S_MODE == I2S_MODE_STD) begin
                    tx_sr_d  = tx_word;
                    tx_cnt_d = '0;
                    dout_d   = 1'b0;
                end else begin
                    tx_sr_d  = {tx_word[DATA_WIDTH-2:0], 1'b0};
                    tx_cnt_d = ONE;
                    dout_d   = tx_word[DATA_WIDTH-1];
                end
            end else if (tx_cnt_q != FULL) begin
                tx_sr_d  = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                tx_cnt_d = tx_cnt_q + ONE;
                dout_d   = tx_sr_q[DATA_WIDTH-1];
            end else begin
                dout_d = 1'b0;
            end
        end
    end

    // all state registers with synchronous reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rx_primed_q <= 1'b0;
            rx_armed_q  <= 1'b0;
            rx_lr_q     <= 1'b0;
            rx_cnt_q    <= '0;
            rx_sr_q     <= '0;
            hold_l_q    <= '0;
            left_ok_q   <= 1'b0;
            in_l_q      <= '0;
            in_r_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            tx_primed_q <= 1'b0;
            tx_lr_q     <= 1'b0;
            tx_cnt_q    <= '0;
            tx_sr_q     <= '0;
            tx_hold_r_q <= '0;
            dout_q      <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            rx_primed_q <= rx_primed_d;
            rx_armed_q  <= rx_armed_d;
            rx_lr_q     <= rx_lr_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_sr_q     <= rx_sr_d;
            hold_l_q    <= hold_l_d;
            left_ok_q   <= left_ok_d;
            in_l_q      <= in_l_d;
            in_r_q      <= in_r_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            tx_primed_q <= tx_primed_d;
            tx_lr_q     <= tx_lr_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_sr_q     <= tx_sr_d;
            tx_hold_r_q <= tx_hold_r_d;
            dout_q      <= dout_d;
            load_q      <= load_d;
        end
    end

    assign oAUD_DATA     = dout_q;
    assign oAUD_inL      = in_l_q;
    assign oAUD_inR      = in_r_q;
    assign oSAMPLE_VALID = valid_q;
    assign oDAC_LOAD     = load_q;
    assign oFRAME_ERR    = ferr_q;

endmodule
